// File: rtl/seq_shift_pkg.sv
// Shared definitions for the sequential shift unit: shift-mode codes and FSM state encoding.
package seq_shift_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_FIN   = 2'b10
  } state_t;

endpackage

// File: rtl/extend_unit.sv
// Combinational IN_W-to-OUT_W extender: sign-extends when i_sign_ext is set, else zero-extends.
module extend_unit #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  i_operand,
  input  logic             i_sign_ext,
  output logic [OUT_W-1:0] o_extended
);

  generate
    if (OUT_W > IN_W) begin : g_ext
      logic w_fill;
      assign w_fill     = i_sign_ext & i_operand[IN_W-1];
      assign o_extended = {{(OUT_W-IN_W){w_fill}}, i_operand};
    end else begin : g_pass
      logic w_unused;
      assign w_unused   = i_sign_ext;
      assign o_extended = i_operand;
    end
  endgenerate

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit: extends an operand and shifts/rotates it STEP positions per clock,
// with a start/busy/done handshake.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned AMT_W = 6,
  parameter int unsigned STEP  = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [IN_W-1:0]  i_operand,
  input  logic [AMT_W-1:0] i_amount,
  input  logic [1:0]       i_mode,
  input  logic             i_sign_ext,
  output logic             o_busy,
  output logic             o_done,
  output logic [OUT_W-1:0] o_result,
  output logic             o_zero
);

  localparam logic [AMT_W-1:0] STEP_A   = AMT_W'(STEP);
  localparam logic [AMT_W-1:0] OUT_A    = AMT_W'(OUT_W);
  localparam logic [AMT_W-1:0] ROR_MASK = AMT_W'(OUT_W - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_busy;
  logic             r_done;
  logic [OUT_W-1:0] r_result;
  logic [AMT_W-1:0] r_count;
  logic [1:0]       r_mode;

  logic [OUT_W-1:0] w_ext;
  logic [AMT_W-1:0] w_k;
  logic [AMT_W-1:0] w_step;
  logic [OUT_W-1:0] w_shifted;
  logic             w_accept;

  extend_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_extend (
    .i_operand  (i_operand),
    .i_sign_ext (i_sign_ext),
    .o_extended (w_ext)
  );

  assign w_accept = (r_state == ST_IDLE) && i_start;

  // Effective count: linear shifts saturate at OUT_W, rotates wrap modulo OUT_W.
  always_comb begin
    w_k = (i_amount > OUT_A) ? OUT_A : i_amount;
    if (i_mode == MODE_ROR) begin
      w_k = i_amount & ROR_MASK;
    end
  end

  // One shift step of min(STEP, remaining) positions.
  always_comb begin
    w_step    = (r_count < STEP_A) ? r_count : STEP_A;
    w_shifted = r_result;
    case (r_mode)
      MODE_SLL: w_shifted = r_result << w_step;
      MODE_SRL: w_shifted = r_result >> w_step;
      MODE_SRA: w_shifted = OUT_W'($signed(r_result) >>> w_step);
      MODE_ROR: w_shifted = (r_result >> w_step) | (r_result << (OUT_A - w_step));
      default:  w_shifted = r_result;
    endcase
  end

  // FSM state and registered handshake flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_SHIFT);
      r_done  <= (w_next == ST_FIN);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next = (w_k != '0) ? ST_SHIFT : ST_FIN;
        end
      end
      ST_SHIFT: begin
        if (r_count == w_step) begin
          w_next = ST_FIN;
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Working register and remaining-count datapath.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_result <= '0;
      r_count  <= '0;
      r_mode   <= MODE_SLL;
    end else if (w_accept) begin
      r_result <= w_ext;
      r_count  <= w_k;
      r_mode   <= i_mode;
    end else if (r_state == ST_SHIFT) begin
      r_result <= w_shifted;
      r_count  <= r_count - w_step;
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_zero   = (r_result == '0);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: a STEP=1 and a STEP=4 instance driven from a vector table.
module tb_seq_shift_unit;

  logic        clk;
  logic        rst;
  logic        start1;
  logic        start4;
  logic [7:0]  operand;
  logic [5:0]  amount;
  logic [1:0]  mode;
  logic        sign_ext;
  logic        busy1, done1, zero1;
  logic        busy4, done4, zero4;
  logic [31:0] result1, result4;

  typedef struct {
    logic [7:0]  op;
    logic [5:0]  amt;
    logic [1:0]  md;
    logic        se;
    logic [31:0] exp;
    int          lat;
    bit          s4;
    bit          inj;
  } vec_t;

  vec_t tbl[14];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  seq_shift_unit #(.IN_W(8), .OUT_W(32), .AMT_W(6), .STEP(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start1), .i_operand(operand),
    .i_amount(amount), .i_mode(mode), .i_sign_ext(sign_ext),
    .o_busy(busy1), .o_done(done1), .o_result(result1), .o_zero(zero1)
  );

  seq_shift_unit #(.IN_W(8), .OUT_W(32), .AMT_W(6), .STEP(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_start(start4), .i_operand(operand),
    .i_amount(amount), .i_mode(mode), .i_sign_ext(sign_ext),
    .o_busy(busy4), .o_done(done4), .o_result(result4), .o_zero(zero4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic cur_done(input bit s4);
    return s4 ? done4 : done1;
  endfunction
  function automatic logic cur_busy(input bit s4);
    return s4 ? busy4 : busy1;
  endfunction
  function automatic logic [31:0] cur_result(input bit s4);
    return s4 ? result4 : result1;
  endfunction
  function automatic logic cur_zero(input bit s4);
    return s4 ? zero4 : zero1;
  endfunction

  // Called at a negedge with the selected DUT idle; capture happens at the next posedge.
  task automatic run_op(input vec_t v);
    vec_t e;
    int   cycles;
    int   busy_n;
    sb.push_back(v);
    operand  = v.op;
    amount   = v.amt;
    mode     = v.md;
    sign_ext = v.se;
    if (v.s4) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    operand  = 8'($urandom);
    amount   = 6'($urandom);
    mode     = 2'($urandom);
    sign_ext = 1'($urandom);
    cycles = 0;
    busy_n = 0;
    while (!cur_done(v.s4) && cycles < 200) begin
      if (cur_busy(v.s4)) busy_n++;
      if (v.inj && cycles == 1) begin
        operand = 8'hFF; amount = 6'd0; mode = 2'b00; sign_ext = 1'b1;
        if (v.s4) start4 = 1'b1; else start1 = 1'b1;
      end else begin
        start1 = 1'b0;
        start4 = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    e = sb.pop_front();
    if (cycles >= 200) begin
      check("done_timeout", 32'(cycles), 32'(e.lat));
    end else begin
      check("latency", 32'(cycles), 32'(e.lat));
      check("busy_cycles", 32'(busy_n), 32'(e.lat));
      check("result", cur_result(v.s4), e.exp);
      check("zero", 32'(cur_zero(v.s4)), 32'(e.exp == 32'h0));
    end
    // Hold start through FIN for injected runs; it must be ignored.
    if (v.inj) begin
      operand = 8'hFF; amount = 6'd0; mode = 2'b00; sign_ext = 1'b1;
      if (v.s4) start4 = 1'b1; else start1 = 1'b1;
    end
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    check("done_pulse_end", 32'(cur_done(v.s4)), 32'h0);
    check("busy_idle", 32'(cur_busy(v.s4)), 32'h0);
    check("result_hold", cur_result(v.s4), e.exp);
  endtask

  initial begin
    //           op     amt    md     se    exp            lat s4 inj
    tbl[0]  = '{8'hFC, 6'd2,  2'b00, 1'b1, 32'hFFFFFFF0, 2,  0, 0};
    tbl[1]  = '{8'h80, 6'd4,  2'b10, 1'b1, 32'hFFFFFFF8, 4,  0, 0};
    tbl[2]  = '{8'h80, 6'd4,  2'b01, 1'b0, 32'h00000008, 4,  0, 0};
    tbl[3]  = '{8'h01, 6'd33, 2'b11, 1'b0, 32'h80000000, 1,  0, 0};
    tbl[4]  = '{8'hFF, 6'd40, 2'b00, 1'b0, 32'h00000000, 32, 0, 0};
    tbl[5]  = '{8'hFF, 6'd63, 2'b10, 1'b1, 32'hFFFFFFFF, 32, 0, 0};
    tbl[6]  = '{8'hA5, 6'd0,  2'b00, 1'b1, 32'hFFFFFFA5, 0,  0, 0};
    tbl[7]  = '{8'h7F, 6'd3,  2'b01, 1'b1, 32'h0000000F, 3,  0, 0};
    tbl[8]  = '{8'h81, 6'd4,  2'b11, 1'b0, 32'h10000008, 4,  0, 0};
    tbl[9]  = '{8'h01, 6'd4,  2'b00, 1'b0, 32'h00000010, 4,  0, 1};
    tbl[10] = '{8'h03, 6'd6,  2'b00, 1'b0, 32'h000000C0, 2,  1, 0};
    tbl[11] = '{8'h80, 6'd7,  2'b10, 1'b1, 32'hFFFFFFFF, 2,  1, 0};
    tbl[12] = '{8'hF0, 6'd31, 2'b11, 1'b0, 32'h000001E0, 8,  1, 0};
    tbl[13] = '{8'hFF, 6'd40, 2'b01, 1'b0, 32'h00000000, 8,  1, 0};

    rst = 1'b1; start1 = 1'b1; start4 = 1'b1;
    operand = 8'hFF; amount = 6'd1; mode = 2'b00; sign_ext = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy1), 32'h0);
    check("reset_done", 32'(done1), 32'h0);
    check("reset_result", result1, 32'h0);
    check("reset_zero", 32'(zero1), 32'h1);
    check("reset_result4", result4, 32'h0);
    rst = 1'b0; start1 = 1'b0; start4 = 1'b0;
    @(negedge clk);

    // Back-to-back: each run_op returns in the IDLE cycle right after FIN.
    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i]);
    end

    // Reset in the middle of a long shift aborts without DONE.
    operand = 8'h01; amount = 6'd10; mode = 2'b00; sign_ext = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy1), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy1), 32'h0);
    check("abort_result", result1, 32'h0);
    check("abort_zero", 32'(zero1), 32'h1);
    begin
      int seen = 0;
      for (int c = 0; c < 20; c++) begin
        if (done1 || busy1) seen++;
        @(negedge clk);
      end
      check("abort_no_done", 32'(seen), 32'h0);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Parametrised multi-cycle shift unit. Extends an IN_W-bit operand to OUT_W bits and shifts or rotates it by a run-time amount, STEP bit positions per clock.
- Generalises the fixed 8-to-32-bit, shift-left-by-2 branch-offset path. Adds selectable sign or zero extension, four shift modes and a start/busy/done handshake.
- Serves the ALU shift instructions and branch/jump offset generation in the pipelined CPU datapath.

Parameters:
- IN_W, 8, operand width; requires 1 <= IN_W <= OUT_W.
- OUT_W, 32, result width; must be a power of two.
- AMT_W, 6, shift-amount width; requires 2**AMT_W > OUT_W.
- STEP, 1, bit positions shifted per cycle; a power of two, with STEP <= OUT_W.

Ports:
- CLK  in  1  clock; rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- OPERAND  in  IN_W  value to extend and shift; captured on accepted START.
- AMOUNT  in  AMT_W  unsigned shift amount; captured on accepted START.
- MODE  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR; captured on accepted START.
- SIGN_EXT  in  1  1 = sign-extend OPERAND, 0 = zero-extend; captured on accepted START.
- BUSY  out  1  high while in SHIFT.
- DONE  out  1  one-cycle pulse; RESULT is final while DONE is high.
- RESULT  out  OUT_W  working/result register.
- ZERO  out  1  combinational (RESULT == 0).

Behaviour:
- Reset: One clock; reset is synchronous and active-high. On RESET the state goes to IDLE, RESULT=0, the counter is cleared, BUSY=0, DONE=0 and ZERO=1. RESET overrides START.
- FSM states: IDLE, SHIFT, FIN.
- Capture (IDLE, START=1, edge T):
  - RESULT loads the extended operand: the upper OUT_W-IN_W bits are OPERAND[IN_W-1] if SIGN_EXT, else 0.
  - The effective count k is loaded. For SLL/SRL/SRA, k = min(AMOUNT, OUT_W). For ROR, k = AMOUNT mod OUT_W (low log2(OUT_W) bits).
  - Next state is SHIFT if k > 0, else FIN.
- SHIFT:
  - Each edge shifts RESULT by s = min(STEP, remaining) positions and subtracts s from the counter.
  - SLL fills with 0. SRL fills with 0. SRA fills with RESULT[OUT_W-1]. ROR rotates right.
  - When the remaining count reaches 0, the next state is FIN.
- FIN: DONE=1 for exactly one cycle, then the state returns to IDLE.
- Latency: with edge T capturing, DONE is high in the cycle after edge T+ceil(k/STEP). For k=0, DONE is high in the cycle after edge T.
- Shift saturation: amounts >= OUT_W give 0 for SLL/SRL and all sign bits for SRA. The natural shift produces this, so no special-case logic is needed.
- Ignored START: START while BUSY or in FIN is ignored. It is not queued.
- RESULT stability: RESULT shows intermediate values during SHIFT. It holds the final value through FIN and IDLE until the next accepted START.
- Back-to-back: START may be asserted in the IDLE cycle immediately after FIN.
- Reset mid-operation: aborts; no DONE is produced.
- Input stability: inputs other than START are don't-care except at the capture edge.

Decomposition:
- Package seq_shift_pkg holds:
  - MODE localparams SLL/SRL/SRA/ROR;
  - the state encoding IDLE/SHIFT/FIN.
- One sub-module, extend_unit, is natural. It is the combinational IN_W-to-OUT_W sign/zero extender, reused by the immediate path.
- The shift step logic and FSM stay in seq_shift_unit.

Test Plan:
- Branch offset: OPERAND=8'hFC, SIGN_EXT=1, SLL, AMOUNT=2 -> RESULT=32'hFFFFFFF0, ZERO=0; DONE in the cycle after edge T+2; BUSY high for 2 cycles.
- Right shifts: 8'h80, SIGN_EXT=1, SRA, AMOUNT=4 -> 32'hFFFFFFF8. 8'h80, SIGN_EXT=0, SRL, AMOUNT=4 -> 32'h00000008.
- Rotate: 8'h01, SIGN_EXT=0, ROR, AMOUNT=33 -> k=1, RESULT=32'h80000000, DONE after edge T+1.
- Saturation: 8'hFF, SIGN_EXT=0, SLL, AMOUNT=40 -> RESULT=0, ZERO=1, DONE after edge T+32. The same operand with SIGN_EXT=1, SRA, AMOUNT=63 -> 32'hFFFFFFFF.
- Handshake: AMOUNT=0 -> DONE in the next cycle, RESULT = extended operand. START asserted while BUSY -> no effect. RESET asserted mid-SHIFT -> BUSY=0, RESULT=0 next cycle, no DONE.
- STEP=4 build: 8'h03, SLL, AMOUNT=6 -> steps of 4 then 2, RESULT=32'h000000C0, DONE after edge T+2.
